jux_axi_wr_bridge: RTL and testbench
====================================

Name: jux_axi_wr_bridge

Overview:
AXI write-path slave that consumes the write address (AW), write data (W) and write response (B) channels driven by the team's AXI master model or a DUT master. It converts each burst into per-beat native memory writes with strobes on a simple ready-throttled port, then returns a write response. It sits directly downstream of an AXI master, in front of an SRAM or register-file model, in block and subsystem benches.

Parameters:
DATA_WIDTH, 3, data bus is (1 << DATA_WIDTH) bytes (DATA_BYTES); DATA_BITS = DATA_BYTES*8
ADDR_WIDTH, 32, byte address width
ID_WIDTH, 4, AXI ID width
AXLEN_WIDTH, 8, AxLEN width (8 = AXI4, 4 = AXI3)

Ports:
aclk  in  1  clock; all logic on posedge
aresetn  in  1  reset, synchronous, active-low
awid  in  ID_WIDTH  write burst ID
awaddr  in  ADDR_WIDTH  burst start byte address
awlen  in  AXLEN_WIDTH  beats minus 1
awsize  in  3  log2 bytes per beat
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_BITS  write data
wstrb  in  DATA_BYTES  byte strobes
wlast  in  1  last beat marker
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  response ID
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
mem_we  out  1  memory write strobe, one beat
mem_addr  out  ADDR_WIDTH  beat byte address
mem_wdata  out  DATA_BITS  equals wdata
mem_wstrb  out  DATA_BYTES  equals wstrb, forced to 0 on error bursts
mem_ready  in  1  memory accepts the beat this cycle

Behaviour:
- One clock (aclk); reset is synchronous and active-low (aresetn). Reset values: state IDLE, awready 1, wready 0, bvalid 0, bid 0, bresp 00, mem_we 0, counters 0.
- FSM states: IDLE, DATA, RESP. Exactly one burst is outstanding at a time.
- IDLE: awready = 1. On awvalid&awready, latch id/addr/len/size/burst, set beat_cnt = 0 and cur_addr = awaddr, compute err, then go to DATA. wready = 0 in IDLE; early W data is not accepted.
- DATA: wready = mem_ready. mem_we = wvalid, combinational. mem_addr = cur_addr.
  - A beat completes on wvalid&wready; mem_we&mem_ready marks the same cycle. First wready is possible in the cycle after the AW handshake.
  - On each beat: if (beat_cnt==len) != wlast, set err.
  - On the beat where beat_cnt == len, go to RESP. Otherwise increment beat_cnt.
- Address update per beat, with step = 1<<size:
  - FIXED: unchanged.
  - INCR: next = (cur_addr & ~(step-1)) + step. An unaligned first beat realigns; wraps modulo 2^ADDR_WIDTH.
  - WRAP: total = step*(len+1), lower = cur_addr & ~(total-1), next = cur+step. If next == lower+total, next = lower.
- AW-time errors (bresp SLVERR, mem_wstrb forced 0, all len+1 beats still consumed):
  - awsize > DATA_WIDTH
  - awburst == 11
  - WRAP with len not in {1,3,7,15}
  - WRAP with awaddr not aligned to step
- RESP: bvalid = 1, bid = latched id, bresp = err ? 10 : 00. These are held stable until bready. On handshake: bvalid 0, go to IDLE, and awready is 1 in the following cycle. Minimum burst-to-burst spacing is 1 idle cycle after B.
- wlast never terminates a burst early; beat count alone ends DATA.
- mem_ready low stalls the beat. Address and beat counter hold.
- Reset mid-burst: the burst is abandoned, no B is issued, and no further mem_we occurs after the reset cycle.

Optional Feature:
JUX_AXI_WR_BRIDGE_STATS_EN:
- Defined: adds outputs stat_bursts[15:0] and stat_errs[15:0]. Both reset to 0. They increment on each B handshake (stat_errs only when bresp = 10) and saturate at 16'hFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- INCR, awaddr 0x100, len 3, size 3, mem_ready=1 -> mem_addr 0x100/108/110/118, mem_we on 4 consecutive cycles, bresp 00, bid=awid.
- WRAP, awaddr 0x118, len 3, size 3 -> mem_addr 0x118/100/108/110, bresp 00.
- INCR, awaddr 0x103, len 1, size 2 -> mem_addr 0x103 then 0x104. FIXED, len 2 -> all beats at awaddr.
- wlast asserted on beat 1 of a len=3 burst -> 4 beats consumed, bresp 10. awsize 4 with DATA_WIDTH 3 -> mem_wstrb 0 on every beat, bresp 10.
- mem_ready toggling 1010… with bready held low 5 cycles -> no beat lost or duplicated, bvalid/bid/bresp stable, awready low until B handshake.
- aresetn low for 1 cycle at beat 2 of a len=7 burst -> bvalid 0, awready 1 after reset, next burst completes normally with bresp 00.

Source files
------------

// File: rtl/jux_axi_wr_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jux_axi_wr_bridge : AXI write slave, bursts -> per-beat strobed mem writes|
// | Option JUX_AXI_WR_BRIDGE_STATS_EN adds burst/error counters. Rev 1.0      |
// +--------------------------------------------------------------------------+
module jux_axi_wr_bridge #(
  parameter int DATA_WIDTH  = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int AXLEN_WIDTH = 8,
  localparam int DATA_BYTES = 1 << DATA_WIDTH,
  localparam int DATA_BITS  = DATA_BYTES * 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [ID_WIDTH-1:0]    awid,
  input  logic [ADDR_WIDTH-1:0]  awaddr,
  input  logic [AXLEN_WIDTH-1:0] awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [DATA_BITS-1:0]   wdata,
  input  logic [DATA_BYTES-1:0]  wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [ID_WIDTH-1:0]    bid,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_BITS-1:0]   mem_wdata,
  output logic [DATA_BYTES-1:0]  mem_wstrb,
  input  logic                   mem_ready
`ifdef JUX_AXI_WR_BRIDGE_STATS_EN
  ,
  output logic [15:0]            stat_bursts,
  output logic [15:0]            stat_errs
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                 state_q;
  logic                   awready_q;
  logic                   bvalid_q;
  logic [ID_WIDTH-1:0]    id_q;
  logic [ID_WIDTH-1:0]    bid_q;
  logic [1:0]             bresp_q;
  logic [1:0]             burst_q;
  logic [2:0]             size_q;
  logic [AXLEN_WIDTH-1:0] len_q;
  logic [AXLEN_WIDTH-1:0] beat_cnt_q;
  logic [ADDR_WIDTH-1:0]  cur_addr_q;
  logic [ADDR_WIDTH-1:0]  cur_addr_d;
  logic                   err_q;
  logic                   aw_err_q;

  logic [ADDR_WIDTH-1:0]  w_step;
  logic [ADDR_WIDTH-1:0]  w_total;
  logic [ADDR_WIDTH-1:0]  w_lower;
  logic [ADDR_WIDTH-1:0]  w_seq;
  logic [ADDR_WIDTH-1:0]  w_aw_step;
  logic                   w_aw_err;
  logic                   w_beat;
  logic                   w_last;
  logic                   w_last_mismatch;

  always_comb begin
    w_step     = ADDR_WIDTH'(1) << size_q;
    w_total    = w_step * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1));
    w_lower    = cur_addr_q & ~(w_total - ADDR_WIDTH'(1));
    w_seq      = cur_addr_q + w_step;
    cur_addr_d = cur_addr_q;
    case (burst_q)
      BURST_INCR:  cur_addr_d = (cur_addr_q & ~(w_step - ADDR_WIDTH'(1))) + w_step;
      BURST_WRAP:  cur_addr_d = (w_seq == (w_lower + w_total)) ? w_lower : w_seq;
      default:     cur_addr_d = cur_addr_q;
    endcase
  end

  // Bursts flagged here still consume every beat, but with strobes suppressed.
  always_comb begin
    w_aw_step = ADDR_WIDTH'(1) << awsize;
    w_aw_err  = 1'b0;
    if (int'(awsize) > DATA_WIDTH) w_aw_err = 1'b1;
    if (awburst == BURST_RSVD)     w_aw_err = 1'b1;
    if (awburst == BURST_WRAP) begin
      if (!(awlen == AXLEN_WIDTH'(1) || awlen == AXLEN_WIDTH'(3) ||
            awlen == AXLEN_WIDTH'(7) || awlen == AXLEN_WIDTH'(15)))
        w_aw_err = 1'b1;
      if ((awaddr & (w_aw_step - ADDR_WIDTH'(1))) != '0)
        w_aw_err = 1'b1;
    end
  end

  assign w_beat          = (state_q == S_DATA) && wvalid && mem_ready;
  assign w_last          = (beat_cnt_q == len_q);
  assign w_last_mismatch = (w_last != wlast);

  assign awready   = awready_q;
  assign wready    = (state_q == S_DATA) && mem_ready;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = (state_q == S_DATA) && wvalid;
  assign mem_addr  = cur_addr_q;
  assign mem_wdata = wdata;
  assign mem_wstrb = aw_err_q ? '0 : wstrb;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      awready_q  <= 1'b1;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      id_q       <= '0;
      burst_q    <= BURST_FIXED;
      size_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      cur_addr_q <= '0;
      err_q      <= 1'b0;
      aw_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (awvalid && awready_q) begin
            id_q       <= awid;
            burst_q    <= awburst;
            size_q     <= awsize;
            len_q      <= awlen;
            beat_cnt_q <= '0;
            cur_addr_q <= awaddr;
            err_q      <= w_aw_err;
            aw_err_q   <= w_aw_err;
            awready_q  <= 1'b0;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            if (w_last_mismatch) err_q <= 1'b1;
            if (w_last) begin
              state_q  <= S_RESP;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q || w_last_mismatch) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              beat_cnt_q <= beat_cnt_q + AXLEN_WIDTH'(1);
              cur_addr_q <= cur_addr_d;
            end
          end
        end
        S_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef JUX_AXI_WR_BRIDGE_STATS_EN
  logic [15:0] stat_bursts_q;
  logic [15:0] stat_errs_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_bursts_q <= '0;
      stat_errs_q   <= '0;
    end else if (state_q == S_RESP && bready) begin
      if (stat_bursts_q != 16'hFFFF) stat_bursts_q <= stat_bursts_q + 16'd1;
      if (bresp_q == RESP_SLVERR && stat_errs_q != 16'hFFFF)
        stat_errs_q <= stat_errs_q + 16'd1;
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jux_axi_wr_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jux_axi_wr_bridge : directed vector bench for jux_axi_wr_bridge        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))
module tb_jux_axi_wr_bridge;

  localparam logic [1:0] FIX  = 2'b00;
  localparam logic [1:0] INC  = 2'b01;
  localparam logic [1:0] WRP  = 2'b10;
  localparam logic [1:0] RSV  = 2'b11;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready;
`ifdef JUX_AXI_WR_BRIDGE_STATS_EN
  logic [15:0] stat_bursts;
  logic [15:0] stat_errs;
`endif

  always #5 aclk = ~aclk;

  jux_axi_wr_bridge u_dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bid       (bid),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready)
`ifdef JUX_AXI_WR_BRIDGE_STATS_EN
    ,
    .stat_bursts (stat_bursts),
    .stat_errs   (stat_errs)
`endif
  );

  // strb_mode: 0 pass-through, 1 forced zero, 2 not checked
  typedef struct packed {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic [7:0]       last_at;
    logic [1:0]       exp_resp;
    logic [1:0]       strb_mode;
    logic             chk_addr;
    logic [3:0][31:0] exp_addr;
  } vec_t;

  vec_t vecs [12];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [3:0] id, input logic [7:0] last_at,
                              input logic [1:0] resp, input logic [1:0] smode,
                              input logic ca, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] a3);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
    v.last_at = last_at; v.exp_resp = resp; v.strb_mode = smode; v.chk_addr = ca;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    return v;
  endfunction

  task automatic run_burst(input vec_t v, input bit toggle, input int bhold, input int tag);
    int          i;
    int          cyc;
    bit          ph;
    logic [63:0] d;
    logic [7:0]  s;
    @(negedge aclk);
    awvalid = 1'b1; awid = v.id; awaddr = v.addr; awlen = v.len;
    awsize = v.size; awburst = v.burst;
    #1 `CHK("awready_idle", awready, 1'b1);
    @(posedge aclk);
    i = 0; cyc = 0; ph = 1'b1;
    while (i <= int'(v.len) && cyc < 100) begin
      @(negedge aclk);
      awvalid   = 1'b0;
      mem_ready = toggle ? ph : 1'b1;
      ph        = ~ph;
      d = {16'hA5A5, 8'(tag), 8'(i), 32'hC0DE_0000 + 32'(i)};
      s = 8'h3C + 8'(i);
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = (8'(i) == v.last_at);
      #1;
      `CHK("awready_busy", awready, 1'b0);
      `CHK("bvalid_busy", bvalid, 1'b0);
      `CHK("wready", wready, mem_ready);
      if (mem_ready) begin
        `CHK("mem_we", mem_we, 1'b1);
        if (v.chk_addr || i == 0) `CHK("mem_addr", mem_addr, v.exp_addr[i[1:0]]);
        `CHK("mem_wdata", mem_wdata, d);
        if (v.strb_mode == 2'd0) `CHK("mem_wstrb", mem_wstrb, s);
        else if (v.strb_mode == 2'd1) `CHK("mem_wstrb_zero", mem_wstrb, 8'h00);
        i++;
      end
      @(posedge aclk);
      cyc++;
    end
    if (cyc >= 100) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", i, int'(v.len) + 1);
    end
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0; mem_ready = 1'b1;
    #1;
    for (int k = 0; k < bhold; k++) begin
      `CHK("hold_bvalid", bvalid, 1'b1);
      `CHK("hold_bid", bid, v.id);
      `CHK("hold_bresp", bresp, v.exp_resp);
      `CHK("hold_awready", awready, 1'b0);
      @(negedge aclk);
      #1;
    end
    bready = 1'b1;
    #1;
    `CHK("bvalid", bvalid, 1'b1);
    `CHK("bid", bid, v.id);
    `CHK("bresp", bresp, v.exp_resp);
    @(posedge aclk);
    @(negedge aclk);
    bready = 1'b0;
    #1;
    `CHK("bvalid_after", bvalid, 1'b0);
    `CHK("awready_after", awready, 1'b1);
  endtask

  initial begin
    aresetn = 1'b0; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0;
    awsize = '0; awburst = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
    wvalid = 1'b0; bready = 1'b0; mem_ready = 1'b1;

    vecs[0]  = mk(32'h100, 8'd3, 3'd3, INC, 4'h5, 8'd3, 2'b00, 2'd0, 1'b1,
                  32'h100, 32'h108, 32'h110, 32'h118);
    vecs[1]  = mk(32'h118, 8'd3, 3'd3, WRP, 4'h6, 8'd3, 2'b00, 2'd0, 1'b1,
                  32'h118, 32'h100, 32'h108, 32'h110);
    vecs[2]  = mk(32'h103, 8'd1, 3'd2, INC, 4'h7, 8'd1, 2'b00, 2'd0, 1'b1,
                  32'h103, 32'h104, 32'h0, 32'h0);
    vecs[3]  = mk(32'h200, 8'd2, 3'd3, FIX, 4'h8, 8'd2, 2'b00, 2'd0, 1'b1,
                  32'h200, 32'h200, 32'h200, 32'h0);
    vecs[4]  = mk(32'h100, 8'd3, 3'd3, INC, 4'h9, 8'd1, 2'b10, 2'd2, 1'b1,
                  32'h100, 32'h108, 32'h110, 32'h118);
    vecs[5]  = mk(32'h100, 8'd1, 3'd4, INC, 4'h1, 8'd1, 2'b10, 2'd1, 1'b1,
                  32'h100, 32'h110, 32'h0, 32'h0);
    vecs[6]  = mk(32'h300, 8'd0, 3'd3, RSV, 4'h2, 8'd0, 2'b10, 2'd1, 1'b1,
                  32'h300, 32'h0, 32'h0, 32'h0);
    vecs[7]  = mk(32'h100, 8'd2, 3'd3, WRP, 4'h3, 8'd2, 2'b10, 2'd1, 1'b0,
                  32'h100, 32'h0, 32'h0, 32'h0);
    vecs[8]  = mk(32'h104, 8'd3, 3'd3, WRP, 4'h4, 8'd3, 2'b10, 2'd1, 1'b0,
                  32'h104, 32'h0, 32'h0, 32'h0);
    vecs[9]  = mk(32'hFFFF_FFF8, 8'd1, 3'd3, INC, 4'hF, 8'd1, 2'b00, 2'd0, 1'b1,
                  32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0);
    vecs[10] = mk(32'h10C, 8'd1, 3'd2, WRP, 4'hC, 8'd1, 2'b00, 2'd0, 1'b1,
                  32'h10C, 32'h108, 32'h0, 32'h0);
    vecs[11] = mk(32'h400, 8'd0, 3'd3, INC, 4'hD, 8'hFF, 2'b10, 2'd0, 1'b1,
                  32'h400, 32'h0, 32'h0, 32'h0);

    repeat (2) @(posedge aclk);
    @(negedge aclk);
    #1;
    `CHK("rst_awready", awready, 1'b1);
    `CHK("rst_wready", wready, 1'b0);
    `CHK("rst_bvalid", bvalid, 1'b0);
    `CHK("rst_bid", bid, 4'h0);
    `CHK("rst_bresp", bresp, 2'b00);
    `CHK("rst_mem_we", mem_we, 1'b0);
    aresetn = 1'b1;

    // W presented while idle must be ignored.
    @(negedge aclk);
    wvalid = 1'b1;
    #1;
    `CHK("early_wready", wready, 1'b0);
    `CHK("early_mem_we", mem_we, 1'b0);
    @(posedge aclk);
    @(negedge aclk);
    wvalid = 1'b0;

    for (int n = 0; n < 12; n++) run_burst(vecs[n], 1'b0, 0, n);

    run_burst(mk(32'h180, 8'd3, 3'd3, INC, 4'hA, 8'd3, 2'b00, 2'd0, 1'b1,
                 32'h180, 32'h188, 32'h190, 32'h198), 1'b1, 5, 12);

    // Reset pulse in the middle of a len=7 burst.
    @(negedge aclk);
    awvalid = 1'b1; awid = 4'h9; awaddr = 32'h500; awlen = 8'd7;
    awsize = 3'd3; awburst = INC; mem_ready = 1'b1;
    @(posedge aclk);
    for (int b = 0; b < 2; b++) begin
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b0; wstrb = 8'hFF; wdata = 64'(b);
      #1 `CHK("rst_pre_addr", mem_addr, 32'h500 + 32'(b * 8));
      @(posedge aclk);
    end
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    `CHK("rst_mid_mem_we", mem_we, 1'b0);
    `CHK("rst_mid_bvalid", bvalid, 1'b0);
    `CHK("rst_mid_awready", awready, 1'b1);
    `CHK("rst_mid_wready", wready, 1'b0);
    repeat (3) begin
      @(posedge aclk);
      @(negedge aclk);
      #1;
      `CHK("rst_post_mem_we", mem_we, 1'b0);
      `CHK("rst_post_bvalid", bvalid, 1'b0);
    end
    wvalid = 1'b0;
    run_burst(vecs[0], 1'b0, 1, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
